// File: rtl/persiana_cmd_conditioner_if.sv
// Command handshake between the input conditioner and the blind FSM.
// The master offers a command code with valid, and the slave accepts it with ready.
interface persiana_cmd_conditioner_if;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/persiana_cmd_conditioner.sv
// Input stage for the blind FSM. It synchronises and debounces the buttons and limit switches.
// It then arbitrates button presses into single commands, which it offers over valid/ready.
module persiana_cmd_conditioner #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic       btn_stop_raw,
  input  logic       lim_top_raw,
  input  logic       lim_bot_raw,
  persiana_cmd_conditioner_if.master cmd,
  output logic       lim_top,
  output logic       lim_bot,
  output logic [2:0] btn_db
);

  typedef enum logic {IDLE, PEND} state_t;
  typedef enum logic [1:0] {CMD_NONE = 2'b00, CMD_UP = 2'b01,
                            CMD_DOWN = 2'b10, CMD_STOP = 2'b11} cmd_t;

  localparam int NIN = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [NIN-1:0]   raw, sync1, sync2, stable;
  logic [CNT_W-1:0] cnt [NIN];
  logic [2:0]       btn_prev;
  logic [2:0]       press;
  cmd_t             new_cmd;
  state_t           state, state_next;
  cmd_t             code_q, code_next;

  assign raw = {lim_bot_raw, lim_top_raw, btn_stop_raw, btn_down_raw, btn_up_raw};

  // An input must disagree with its stable level for DB_CYCLES consecutive clocks before it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      btn_prev <= '0;
      for (int i = 0; i < NIN; i++) cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      btn_prev <= stable[2:0];
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] != stable[i]) begin
          if (cnt[i] == CNT_LAST) begin
            stable[i] <= sync2[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign press   = stable[2:0] & ~btn_prev;
  assign btn_db  = stable[2:0];
  assign lim_top = stable[3];
  assign lim_bot = stable[4];

  always_comb begin
    new_cmd = CMD_NONE;
    if (press[2] || (press[0] && press[1])) new_cmd = CMD_STOP;
    else if (press[0])                      new_cmd = lim_top ? CMD_NONE : CMD_UP;
    else if (press[1])                      new_cmd = lim_bot ? CMD_NONE : CMD_DOWN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      code_q <= CMD_NONE;
    end else begin
      state  <= state_next;
      code_q <= code_next;
    end
  end

  // A pending STOP cannot be replaced by UP or DOWN until the FSM has taken it.
  always_comb begin
    state_next = state;
    code_next  = code_q;
    case (state)
      IDLE: begin
        if (new_cmd != CMD_NONE) begin
          state_next = PEND;
          code_next  = new_cmd;
        end
      end
      PEND: begin
        if (cmd.cmd_ready) begin
          if (new_cmd != CMD_NONE) begin
            code_next = new_cmd;
          end else begin
            state_next = IDLE;
            code_next  = CMD_NONE;
          end
        end else if (new_cmd == CMD_STOP) begin
          code_next = CMD_STOP;
        end else if (new_cmd != CMD_NONE && code_q != CMD_STOP) begin
          code_next = new_cmd;
        end
      end
      default: begin
        state_next = IDLE;
        code_next  = CMD_NONE;
      end
    endcase
  end

  always_comb begin
    cmd.cmd_valid = 1'b0;
    cmd.cmd_code  = CMD_NONE;
    if (state == PEND) begin
      cmd.cmd_valid = 1'b1;
      cmd.cmd_code  = code_q;
    end
  end

endmodule

// File: tb/tb_persiana_cmd_conditioner.sv
// Directed bench for persiana_cmd_conditioner with DB_CYCLES=4.
// Inputs are driven 1 time unit after a rising edge, and outputs are sampled 1 time unit after an edge.
module tb_persiana_cmd_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up_raw, btn_down_raw, btn_stop_raw, lim_top_raw, lim_bot_raw;
  logic       lim_top, lim_bot;
  logic [2:0] btn_db;
  int         checks = 0;
  int         errors = 0;
  int         up_xfers = 0;

  persiana_cmd_conditioner_if bus ();

  persiana_cmd_conditioner #(.DB_CYCLES(4), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_up_raw   (btn_up_raw),
    .btn_down_raw (btn_down_raw),
    .btn_stop_raw (btn_stop_raw),
    .lim_top_raw  (lim_top_raw),
    .lim_bot_raw  (lim_bot_raw),
    .cmd          (bus),
    .lim_top      (lim_top),
    .lim_bot      (lim_bot),
    .btn_db       (btn_db)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.cmd_valid && bus.cmd_ready && bus.cmd_code == 2'b01) up_xfers++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic up, input logic down, input logic stop,
                               input logic top, input logic bot);
    btn_up_raw   = up;
    btn_down_raw = down;
    btn_stop_raw = stop;
    lim_top_raw  = top;
    lim_bot_raw  = bot;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.cmd_ready = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    tick(3);
    checks++;
    if ({bus.cmd_valid, bus.cmd_code, lim_top, lim_bot, btn_db} !== 8'b0) begin
      errors++;
      $display("[TB] FAIL reset_state got %b want 00000000",
               {bus.cmd_valid, bus.cmd_code, lim_top, lim_bot, btn_db});
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_up_hold;
    applyStimulus(1, 0, 0, 0, 0);
    tick(6);
    checks++;
    if (btn_db !== 3'b001 || bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL up_stable_edge6 got db=%b valid=%b want db=001 valid=0", btn_db, bus.cmd_valid);
    end
    tick(1);
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 2'b01) begin
      errors++;
      $display("[TB] FAIL up_valid_edge7 got valid=%b code=%b want 1/01", bus.cmd_valid, bus.cmd_code);
    end
    tick(13);
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 2'b01) begin
      errors++;
      $display("[TB] FAIL up_held_no_ready got valid=%b code=%b want 1/01", bus.cmd_valid, bus.cmd_code);
    end
    bus.cmd_ready = 1'b1;
    tick(1);
    bus.cmd_ready = 1'b0;
    checks++;
    if (bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL up_accept_drop got valid=%b want 0", bus.cmd_valid);
    end
    applyStimulus(0, 0, 0, 0, 0);
    tick(8);
    checks++;
    if (bus.cmd_valid !== 1'b0 || btn_db !== 3'b000) begin
      errors++;
      $display("[TB] FAIL up_release_no_event got valid=%b db=%b want 0/000", bus.cmd_valid, btn_db);
    end
  endtask

  task automatic test_glitch;
    applyStimulus(0, 1, 0, 0, 0);
    tick(3);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (bus.cmd_valid !== 1'b0 || btn_db !== 3'b000) begin
        errors++;
        $display("[TB] FAIL glitch_cycle%0d got valid=%b db=%b want 0/000", i, bus.cmd_valid, btn_db);
      end
    end
  endtask

  task automatic test_arbitration;
    applyStimulus(1, 1, 0, 0, 0);
    tick(7);
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 2'b11) begin
      errors++;
      $display("[TB] FAIL updown_stop got valid=%b code=%b want 1/11", bus.cmd_valid, bus.cmd_code);
    end
    applyStimulus(0, 0, 0, 0, 0);
    tick(8);
    applyStimulus(1, 0, 0, 0, 0);
    tick(8);
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 2'b11 || btn_db !== 3'b001) begin
      errors++;
      $display("[TB] FAIL stop_sticky got valid=%b code=%b db=%b want 1/11/001",
               bus.cmd_valid, bus.cmd_code, btn_db);
    end
    bus.cmd_ready = 1'b1;
    tick(1);
    bus.cmd_ready = 1'b0;
    checks++;
    if (bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stop_accept got valid=%b want 0", bus.cmd_valid);
    end
    applyStimulus(0, 0, 0, 0, 0);
    tick(8);
  endtask

  task automatic test_limits;
    applyStimulus(0, 0, 0, 1, 0);
    tick(6);
    checks++;
    if (lim_top !== 1'b1 || lim_bot !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lim_top_level got top=%b bot=%b want 1/0", lim_top, lim_bot);
    end
    applyStimulus(1, 0, 0, 1, 0);
    tick(10);
    checks++;
    if (bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL up_gated_top got valid=%b want 0", bus.cmd_valid);
    end
    applyStimulus(0, 0, 0, 1, 0);
    tick(8);
    applyStimulus(0, 1, 0, 1, 0);
    tick(7);
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 2'b10) begin
      errors++;
      $display("[TB] FAIL down_at_top got valid=%b code=%b want 1/10", bus.cmd_valid, bus.cmd_code);
    end
    bus.cmd_ready = 1'b1;
    tick(1);
    bus.cmd_ready = 1'b0;
    applyStimulus(0, 0, 0, 0, 1);
    tick(8);
    checks++;
    if (lim_top !== 1'b0 || lim_bot !== 1'b1 || bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lim_bot_level got top=%b bot=%b valid=%b want 0/1/0", lim_top, lim_bot, bus.cmd_valid);
    end
    applyStimulus(0, 1, 0, 0, 1);
    tick(10);
    checks++;
    if (bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL down_gated_bot got valid=%b want 0", bus.cmd_valid);
    end
    applyStimulus(0, 0, 0, 0, 0);
    tick(8);
  endtask

  task automatic test_back_to_back;
    int xfers_before;
    applyStimulus(1, 0, 0, 0, 0);
    tick(7);
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 2'b01) begin
      errors++;
      $display("[TB] FAIL b2b_up_pending got valid=%b code=%b want 1/01", bus.cmd_valid, bus.cmd_code);
    end
    xfers_before = up_xfers;
    applyStimulus(1, 1, 0, 0, 0);
    tick(6);
    bus.cmd_ready = 1'b1;
    tick(1);
    bus.cmd_ready = 1'b0;
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 2'b10) begin
      errors++;
      $display("[TB] FAIL b2b_no_bubble got valid=%b code=%b want 1/10", bus.cmd_valid, bus.cmd_code);
    end
    checks++;
    if (up_xfers - xfers_before !== 1) begin
      errors++;
      $display("[TB] FAIL b2b_up_transfers got %0d want 1", up_xfers - xfers_before);
    end
    bus.cmd_ready = 1'b1;
    tick(1);
    bus.cmd_ready = 1'b0;
    checks++;
    if (bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_down_accept got valid=%b want 0", bus.cmd_valid);
    end
    applyStimulus(0, 0, 0, 0, 0);
    tick(8);
  endtask

  task automatic test_reset_mid;
    applyStimulus(1, 0, 0, 0, 0);
    tick(7);
    applyStimulus(1, 0, 1, 0, 0);
    tick(3);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      checks++;
      if ({bus.cmd_valid, bus.cmd_code, lim_top, lim_bot, btn_db} !== 8'b0) begin
        errors++;
        $display("[TB] FAIL rst_mid_cycle%0d got %b want 00000000", i,
                 {bus.cmd_valid, bus.cmd_code, lim_top, lim_bot, btn_db});
      end
    end
    rst = 1'b0;
    tick(5);
    checks++;
    if (btn_db !== 3'b000 || bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_release_early got db=%b valid=%b want 000/0", btn_db, bus.cmd_valid);
    end
    tick(1);
    checks++;
    if (btn_db !== 3'b101 || bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_release_stable got db=%b valid=%b want 101/0", btn_db, bus.cmd_valid);
    end
    tick(1);
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 2'b11) begin
      errors++;
      $display("[TB] FAIL rst_release_stop got valid=%b code=%b want 1/11", bus.cmd_valid, bus.cmd_code);
    end
    bus.cmd_ready = 1'b1;
    tick(1);
    bus.cmd_ready = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    tick(8);
  endtask

  initial begin
    test_reset();
    test_up_hold();
    test_glitch();
    test_arbitration();
    test_limits();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
